// File: rtl/brpred_perf_monitor_if.sv
// Monitor tap bus: the pipeline-side signals observed by the branch
// predictor performance monitor. The driver side (CPU or bench) uses the
// master view and the monitor uses the slave view.
interface brpred_perf_monitor_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
);

    logic              stall;
    logic              flush;
    logic              brType;
    logic [ADDR_W-1:0] iAddr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              wen;

    modport master (
        output stall,
        output flush,
        output brType,
        output iAddr,
        output addr,
        output data,
        output wen
    );

    modport slave (
        input stall,
        input flush,
        input brType,
        input iAddr,
        input addr,
        input data,
        input wen
    );

endinterface

// File: rtl/brpred_perf_monitor.sv
// Branch predictor performance monitor.
// Watches the pipeline through the monitor tap bus, counts stalls, flushes,
// branches and fetched instructions, and tracks a sequence of self-test
// parts that report their result by writing to data-memory word address 0
// (data 0 = pass, anything else = fail). Once every part has passed, or the
// optional cycle limit expires, all statistics freeze and finish_o rises.
module brpred_perf_monitor #(
    parameter int          NUM_PARTS = 3,
    parameter int          CNT_W     = 16,
    parameter int          ERR_W     = 8,
    parameter int          ADDR_W    = 30,
    parameter int          DATA_W    = 32,
    parameter int unsigned TIMEOUT   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    brpred_perf_monitor_if.slave     bus_i,
    output logic [ERR_W-1:0]         errorNum_o,
    output logic [CNT_W-1:0]         duration_o,
    output logic [CNT_W-1:0]         stallCycles_o,
    output logic [CNT_W-1:0]         flushTimes_o,
    output logic [CNT_W-1:0]         branchCount_o,
    output logic [CNT_W-1:0]         instructionCount_o,
    output logic [NUM_PARTS-1:0]     partDone_o,
    output logic                     finish_o,
    output logic                     timeout_o
);

    // Part index width; kept at least one bit so a single-part build still elaborates.
    localparam int IDX_W = (NUM_PARTS > 1) ? $clog2(NUM_PARTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PARTS - 1);

    // A cycle limit that the duration counter can never represent would never fire,
    // so it is disabled outright instead of being truncated into a false match.
    localparam bit TIMEOUT_EN = (TIMEOUT != 0) &&
                                ((CNT_W >= 32) ||
                                 (64'(TIMEOUT) <= ((64'd1 << CNT_W) - 64'd1)));
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic {
        WEN_ARMED,
        WEN_HELD
    } wenState_e;

    typedef enum logic {
        MON_PART,
        MON_DONE
    } monState_e;

    wenState_e          wenState_q, wenState_d;
    monState_e          state_q, state_d;
    logic [IDX_W-1:0]   partIdx_q, partIdx_d;
    logic [NUM_PARTS-1:0] partDone_q, partDone_d;
    logic [ERR_W-1:0]   errorNum_q, errorNum_d;
    logic [CNT_W-1:0]   duration_q, duration_d;
    logic [CNT_W-1:0]   stallCycles_q, stallCycles_d;
    logic [CNT_W-1:0]   flushTimes_q, flushTimes_d;
    logic [CNT_W-1:0]   branchCount_q, branchCount_d;
    logic [CNT_W-1:0]   instrCount_q, instrCount_d;
    logic [ADDR_W-1:0]  prevAddr_q, prevAddr_d;
    logic               timeout_q, timeout_d;

    logic               writeAccept;
    logic [ADDR_W-1:0]  wrAddr;
    logic [DATA_W-1:0]  wrData;

    // Saturating increment for the performance counters.
    function automatic logic [CNT_W-1:0] satCnt(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    // Saturating increment for the error counter.
    function automatic logic [ERR_W-1:0] satErr(input logic [ERR_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + ERR_W'(1) : v;
    endfunction

    assign wrAddr = bus_i.addr;
    assign wrData = bus_i.data;

    // A long wen pulse is one write: only the first cycle of the pulse counts.
    assign writeAccept = bus_i.wen && (wenState_q == WEN_ARMED);

    // Write-accept tracker: armed while wen is low, held while wen stays high.
    always_comb begin
        wenState_d = wenState_q;
        case (wenState_q)
            WEN_ARMED: if (bus_i.wen)  wenState_d = WEN_HELD;
            WEN_HELD:  if (!bus_i.wen) wenState_d = WEN_ARMED;
            default:   wenState_d = WEN_ARMED;
        endcase
    end

    // Main sequencing and statistics: advance through the parts on pass writes,
    // count events while running, and freeze everything once done.
    always_comb begin
        state_d       = state_q;
        partIdx_d     = partIdx_q;
        partDone_d    = partDone_q;
        errorNum_d    = errorNum_q;
        duration_d    = duration_q;
        stallCycles_d = stallCycles_q;
        flushTimes_d  = flushTimes_q;
        branchCount_d = branchCount_q;
        instrCount_d  = instrCount_q;
        timeout_d     = timeout_q;
        prevAddr_d    = bus_i.iAddr;

        if (state_q == MON_PART) begin
            duration_d    = satCnt(duration_q, 1'b1);
            stallCycles_d = satCnt(stallCycles_q, bus_i.stall);
            flushTimes_d  = satCnt(flushTimes_q, bus_i.flush);
            branchCount_d = satCnt(branchCount_q, bus_i.brType);
            instrCount_d  = satCnt(instrCount_q, bus_i.iAddr != prevAddr_q);

            if (writeAccept && (wrAddr == '0)) begin
                if (wrData == '0) begin
                    partDone_d[partIdx_q] = 1'b1;
                    if (partIdx_q == LAST_IDX) begin
                        state_d = MON_DONE;
                    end else begin
                        partIdx_d = partIdx_q + IDX_W'(1);
                    end
                end else begin
                    errorNum_d = satErr(errorNum_q, 1'b1);
                end
            end

            // A pass in the final cycle wins; the limit only fires if the run is still open.
            if (TIMEOUT_EN && (state_d != MON_DONE) && (duration_d == TIMEOUT_CNT)) begin
                state_d   = MON_DONE;
                timeout_d = 1'b1;
            end
        end
    end

    // State and statistics registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wenState_q    <= WEN_ARMED;
            state_q       <= MON_PART;
            partIdx_q     <= '0;
            partDone_q    <= '0;
            errorNum_q    <= '0;
            duration_q    <= '0;
            stallCycles_q <= '0;
            flushTimes_q  <= '0;
            branchCount_q <= '0;
            instrCount_q  <= '0;
            prevAddr_q    <= '0;
            timeout_q     <= 1'b0;
        end else begin
            wenState_q    <= wenState_d;
            state_q       <= state_d;
            partIdx_q     <= partIdx_d;
            partDone_q    <= partDone_d;
            errorNum_q    <= errorNum_d;
            duration_q    <= duration_d;
            stallCycles_q <= stallCycles_d;
            flushTimes_q  <= flushTimes_d;
            branchCount_q <= branchCount_d;
            instrCount_q  <= instrCount_d;
            prevAddr_q    <= prevAddr_d;
            timeout_q     <= timeout_d;
        end
    end

    assign errorNum_o         = errorNum_q;
    assign duration_o         = duration_q;
    assign stallCycles_o      = stallCycles_q;
    assign flushTimes_o       = flushTimes_q;
    assign branchCount_o      = branchCount_q;
    assign instructionCount_o = instrCount_q;
    assign partDone_o         = partDone_q;
    assign timeout_o          = timeout_q;
    assign finish_o           = (state_q == MON_DONE);

endmodule

// File: tb/tb_brpred_perf_monitor.sv
// Bench for brpred_perf_monitor: three instances (default, 4-bit counters,
// 50-cycle limit) share one stimulus bus and are compared every cycle against
// an integer-level model, with literal checks at key points of the run.
module tb_brpred_perf_monitor;

    localparam int NP = 3;

    logic clk;
    logic rst;

    brpred_perf_monitor_if #(.ADDR_W(30), .DATA_W(32)) bus ();

    logic [7:0]  errA, errB, errC;
    logic [15:0] durA, stlA, flA, brA, insA;
    logic [3:0]  durB, stlB, flB, brB, insB;
    logic [15:0] durC, stlC, flC, brC, insC;
    logic [2:0]  pdA, pdB, pdC;
    logic        finA, finB, finC;
    logic        toA, toB, toC;

    int compared = 0;
    int mismatched = 0;
    bit checkEn = 0;

    // Model state, one slot per instance
    int capCnt [NP] = '{65535, 15, 65535};
    int tmo    [NP] = '{0, 0, 50};
    int mDur [NP], mStall [NP], mFlush [NP], mBr [NP], mInstr [NP], mErr [NP], mParts [NP];
    bit mDone [NP], mTo [NP];
    bit mWenPrev;
    logic [29:0] mPrevAddr;

    brpred_perf_monitor dutA (
        .clk(clk), .rst(rst), .bus_i(bus),
        .errorNum_o(errA), .duration_o(durA), .stallCycles_o(stlA), .flushTimes_o(flA),
        .branchCount_o(brA), .instructionCount_o(insA), .partDone_o(pdA),
        .finish_o(finA), .timeout_o(toA)
    );

    brpred_perf_monitor #(.CNT_W(4)) dutB (
        .clk(clk), .rst(rst), .bus_i(bus),
        .errorNum_o(errB), .duration_o(durB), .stallCycles_o(stlB), .flushTimes_o(flB),
        .branchCount_o(brB), .instructionCount_o(insB), .partDone_o(pdB),
        .finish_o(finB), .timeout_o(toB)
    );

    brpred_perf_monitor #(.TIMEOUT(50)) dutC (
        .clk(clk), .rst(rst), .bus_i(bus),
        .errorNum_o(errC), .duration_o(durC), .stallCycles_o(stlC), .flushTimes_o(flC),
        .branchCount_o(brC), .instructionCount_o(insC), .partDone_o(pdC),
        .finish_o(finC), .timeout_o(toC)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the run ever fails to reach its summary
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int sat(input int v, input int cap);
        return (v > cap) ? cap : v;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NP; i++) begin
            mDur[i] = 0; mStall[i] = 0; mFlush[i] = 0; mBr[i] = 0; mInstr[i] = 0;
            mErr[i] = 0; mParts[i] = 0; mDone[i] = 0; mTo[i] = 0;
        end
        mWenPrev  = 0;
        mPrevAddr = '0;
    endtask

    // Model: a write is the rising edge of wen; a pass is such a write of 0 to
    // address 0; the run ends after NP passes or when the cycle count hits the limit.
    task automatic modelStep();
        bit rise;
        bit moved;
        rise  = bus.wen && !mWenPrev;
        moved = (bus.iAddr != mPrevAddr);
        for (int i = 0; i < NP; i++) begin
            if (!mDone[i]) begin
                mDur[i]   = sat(mDur[i] + 1, capCnt[i]);
                mStall[i] = sat(mStall[i] + int'(bus.stall), capCnt[i]);
                mFlush[i] = sat(mFlush[i] + int'(bus.flush), capCnt[i]);
                mBr[i]    = sat(mBr[i] + int'(bus.brType), capCnt[i]);
                mInstr[i] = sat(mInstr[i] + int'(moved), capCnt[i]);
                if (rise && bus.addr == 0) begin
                    if (bus.data == 0) begin
                        mParts[i]++;
                        if (mParts[i] == NP) mDone[i] = 1;
                    end else begin
                        mErr[i] = sat(mErr[i] + 1, 255);
                    end
                end
                if (!mDone[i] && tmo[i] != 0 && mDur[i] == tmo[i]) begin
                    mDone[i] = 1;
                    mTo[i]   = 1;
                end
            end
        end
        mWenPrev  = bus.wen;
        mPrevAddr = bus.iAddr;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) modelReset();
        else     modelStep();
    end

    task automatic compareInst(input int i, input string tag,
                               input int dur, input int stl, input int fl, input int br,
                               input int ins, input int err, input int pd,
                               input int fin, input int to);
        checkOutput({tag, ".duration"},     dur, mDur[i]);
        checkOutput({tag, ".stall_cycles"}, stl, mStall[i]);
        checkOutput({tag, ".flush_times"},  fl,  mFlush[i]);
        checkOutput({tag, ".branch_count"}, br,  mBr[i]);
        checkOutput({tag, ".instr_count"},  ins, mInstr[i]);
        checkOutput({tag, ".error_num"},    err, mErr[i]);
        checkOutput({tag, ".part_done"},    pd,  (1 << mParts[i]) - 1);
        checkOutput({tag, ".finish"},       fin, int'(mDone[i]));
        checkOutput({tag, ".timeout"},      to,  int'(mTo[i]));
    endtask

    // Every cycle, just after the edge, all three instances against the model
    always @(posedge clk) begin
        #1;
        if (checkEn) begin
            compareInst(0, "A", int'(durA), int'(stlA), int'(flA), int'(brA), int'(insA),
                        int'(errA), int'(pdA), int'(finA), int'(toA));
            compareInst(1, "B", int'(durB), int'(stlB), int'(flB), int'(brB), int'(insB),
                        int'(errB), int'(pdB), int'(finB), int'(toB));
            compareInst(2, "C", int'(durC), int'(stlC), int'(flC), int'(brC), int'(insC),
                        int'(errC), int'(pdC), int'(finC), int'(toC));
        end
    end

    // Drive one cycle of inputs at the falling edge and let one rising edge pass
    task automatic applyStimulus(input bit s, input bit f, input bit b, input int ia,
                                 input int a, input int d, input bit w);
        bus.stall  = s;
        bus.flush  = f;
        bus.brType = b;
        bus.iAddr  = 30'(ia);
        bus.addr   = 30'(a);
        bus.data   = 32'(d);
        bus.wen    = w;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus.stall = 0; bus.flush = 0; bus.brType = 0;
        bus.iAddr = '0; bus.addr = '0; bus.data = '0; bus.wen = 0;
        repeat (2) @(negedge clk);
        checkEn = 1;

        // Reset state
        checkOutput("reset A.duration", int'(durA), 0);
        checkOutput("reset A.part_done", int'(pdA), 0);
        checkOutput("reset A.finish", int'(finA), 0);
        checkOutput("reset C.timeout", int'(toC), 0);
        rst = 1'b0;

        // All events together for 10 cycles with a moving fetch address
        for (int k = 1; k <= 10; k++) applyStimulus(1, 1, 1, k, 0, 0, 0);
        checkOutput("events A.stall_cycles", int'(stlA), 10);
        checkOutput("events A.flush_times", int'(flA), 10);
        checkOutput("events A.branch_count", int'(brA), 10);
        checkOutput("events A.instr_count", int'(insA), 10);

        // Stall held 20 more cycles: 4-bit instance pins at 15
        for (int k = 0; k < 20; k++) applyStimulus(1, 0, 0, 10, 0, 0, 0);
        checkOutput("saturate B.stall_cycles", int'(stlB), 15);
        checkOutput("saturate A.stall_cycles", int'(stlA), 30);
        checkOutput("saturate B.duration", int'(durB), 15);

        // Failing write held for 5 cycles counts once
        for (int k = 0; k < 5; k++) applyStimulus(0, 0, 0, 10, 0, 5, 1);
        applyStimulus(0, 0, 0, 10, 0, 0, 0);
        checkOutput("long wen A.error_num", int'(errA), 1);
        checkOutput("long wen A.part_done", int'(pdA), 0);

        // Pass pattern at a nonzero address is ignored
        applyStimulus(0, 0, 0, 10, 5, 0, 1);
        applyStimulus(0, 0, 0, 10, 0, 0, 0);
        checkOutput("addr!=0 A.part_done", int'(pdA), 0);

        // Idle until the 50-cycle instance expires
        for (int k = 0; k < 20; k++) applyStimulus(0, 0, 0, 10, 0, 0, 0);
        checkOutput("limit C.finish", int'(finC), 1);
        checkOutput("limit C.timeout", int'(toC), 1);
        checkOutput("limit C.duration", int'(durC), 50);
        checkOutput("limit C.part_done", int'(pdC), 0);
        checkOutput("limit A.finish", int'(finA), 0);

        // Three single-cycle pass writes
        applyStimulus(0, 0, 0, 10, 0, 0, 1);
        checkOutput("pass1 A.part_done", int'(pdA), 1);
        applyStimulus(0, 0, 0, 10, 0, 0, 0);
        applyStimulus(0, 0, 0, 10, 0, 0, 1);
        checkOutput("pass2 A.part_done", int'(pdA), 3);
        applyStimulus(0, 0, 0, 10, 0, 0, 0);
        checkOutput("pass2 A.finish", int'(finA), 0);
        applyStimulus(0, 0, 0, 10, 0, 0, 1);
        checkOutput("pass3 A.part_done", int'(pdA), 7);
        checkOutput("pass3 A.finish", int'(finA), 1);
        checkOutput("pass3 A.timeout", int'(toA), 0);
        applyStimulus(0, 0, 0, 10, 0, 0, 0);

        // Activity after finish has no effect
        for (int k = 0; k < 5; k++) applyStimulus(1, 1, 1, 20 + k, 0, 0, 0);
        applyStimulus(0, 0, 0, 30, 0, 7, 1);
        applyStimulus(0, 0, 0, 30, 0, 0, 0);
        checkOutput("frozen A.stall_cycles", int'(stlA), 30);
        checkOutput("frozen C.stall_cycles", int'(stlC), 30);
        checkOutput("frozen A.error_num", int'(errA), 1);
        checkOutput("frozen C.part_done", int'(pdC), 0);

        // Fresh run, pass two parts, then reset mid-run
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("rerun A.part_done", int'(pdA), 3);
        rst = 1'b1;
        #2;
        checkOutput("midreset A.part_done", int'(pdA), 0);
        checkOutput("midreset A.duration", int'(durA), 0);
        checkOutput("midreset C.finish", int'(finC), 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("afterreset A.part_done", int'(pdA), 1);
        checkOutput("afterreset A.error_num", int'(errA), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
